// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: the boot state encoding seen on the state output.
package boot_pkg;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } boot_state_t;

endpackage

// File: rtl/boot_sequencer_if.sv
// Byte-stream bundle around the boot sequencer: UART rx in, loader and core streams out.
interface boot_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              loader_valid;
  logic [DATA_W-1:0] loader_data;
  logic              loader_ready;
  logic              core_rx_valid;
  logic [DATA_W-1:0] core_rx_data;
  logic              core_rx_ready;

  // master is the sequencer side of every stream; slave is the surrounding system
  modport master (
    input  rx_valid, rx_data, loader_ready, core_rx_ready,
    output rx_ready, loader_valid, loader_data, core_rx_valid, core_rx_data
  );

  modport slave (
    output rx_valid, rx_data, loader_ready, core_rx_ready,
    input  rx_ready, loader_valid, loader_data, core_rx_valid, core_rx_data
  );
endinterface

// File: rtl/idle_timer.sv
// Rx silence timer: armed by the first accepted byte, counts consecutive silent cycles, saturating.
module idle_timer #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic arm,
  input  logic tick,
  output logic expired
);
  localparam int                CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LIMIT - 1);

  logic             r_armed;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_armed <= 1'b0;
      r_count <= '0;
    end else if (arm) begin
      r_armed <= 1'b1;
      r_count <= '0;
    end else if (r_armed) begin
      // any cycle with traffic (including stalled traffic) restarts the silence count
      if (!tick) begin
        r_count <= '0;
      end else if (r_count != LAST) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign expired = r_armed && tick && (r_count == LAST);

endmodule

// File: rtl/boot_sequencer.sv
// Boot controller: holds the core in reset while the UART stream feeds the loader, then hands the stream to the core.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  boot_sequencer_if.master bus,
  output logic             loader_reset,
  input  logic             loader_completed,
  output logic             core_reset,
  input  logic             reload_request,
  output boot_state_t      state,
  output logic             booted,
  output logic             load_error
);
  localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  boot_state_t         r_state;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic                r_load_error;

  logic w_timer_clear;
  logic w_timer_arm;
  logic w_timer_tick;
  logic w_expired;

  assign w_timer_clear = (r_state != S_LOAD);
  assign w_timer_arm   = (r_state == S_LOAD) && bus.rx_valid && bus.rx_ready;
  assign w_timer_tick  = !bus.rx_valid;

  idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .arm     (w_timer_arm),
    .tick    (w_timer_tick),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_settle_cnt <= '0;
      r_load_error <= 1'b0;
    end else if (reload_request) begin
      r_state      <= S_INIT;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT: r_state <= S_LOAD;
        S_LOAD: begin
          // completion wins over a coincident timeout and leaves load_error clear
          if (loader_completed) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
            r_load_error <= 1'b0;
          end else if (w_expired) begin
            r_state      <= S_INIT;
            r_load_error <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // routing follows the registered state, so a byte taken in the last S_LOAD cycle stays with the loader
  always_comb begin
    bus.rx_ready      = 1'b0;
    bus.loader_valid  = 1'b0;
    bus.core_rx_valid = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.loader_valid = bus.rx_valid;
        bus.rx_ready     = bus.loader_ready;
      end
      S_RUN: begin
        bus.core_rx_valid = bus.rx_valid;
        bus.rx_ready      = bus.core_rx_ready;
      end
      default: ;
    endcase
  end

  assign bus.loader_data  = bus.rx_data;
  assign bus.core_rx_data = bus.rx_data;

  assign loader_reset = (r_state == S_INIT);
  assign core_reset   = (r_state != S_RUN);
  assign booted       = (r_state == S_RUN);
  assign state        = r_state;
  assign load_error   = r_load_error;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with SETTLE_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_boot_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       loader_completed;
  logic       reload_request;
  logic       loader_reset;
  logic       core_reset;
  logic       booted;
  logic       load_error;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  boot_sequencer_if #(.DATA_W(8)) bus ();

  boot_sequencer #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .loader_reset     (loader_reset),
    .loader_completed (loader_completed),
    .core_reset       (core_reset),
    .reload_request   (reload_request),
    .state            (state),
    .booted           (booted),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.loader_ready  = 1'b1;
    bus.core_rx_ready = 1'b0;
    loader_completed  = 1'b0;
    reload_request    = 1'b0;
  endtask

  // leaves the bench in cycle 0 after reset release (S_INIT)
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic go_load();
    do_reset();
    step();
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = base + 8'(i);
      step();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic complete();
    loader_completed = 1'b1;
    step();
    loader_completed = 1'b0;
  endtask

  task automatic boot_to_run();
    go_load();
    send_bytes(2, 8'h20);
    complete();
    repeat (4) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rx_valid      = 1'b1;
    bus.core_rx_ready = 1'b1;
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (loader_reset !== 1'b1) begin errors++; $display("FAIL rst_loader_reset got %b exp 1", loader_reset); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %b exp 1", core_reset); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got %b exp 0", bus.rx_ready); end
    checks++; if (bus.loader_valid !== 1'b0) begin errors++; $display("FAIL rst_loader_valid got %b exp 0", bus.loader_valid); end
    checks++; if (bus.core_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_core_rx_valid got %b exp 0", bus.core_rx_valid); end
    checks++; if (booted !== 1'b0) begin errors++; $display("FAIL rst_booted got %b exp 0", booted); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_load_error got %b exp 0", load_error); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL cyc0_state got %0d exp 0", state); end
    checks++; if (loader_reset !== 1'b1) begin errors++; $display("FAIL cyc0_loader_reset got %b exp 1", loader_reset); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL cyc0_rx_ready got %b exp 0", bus.rx_ready); end
    step();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL cyc1_state got %0d exp 1", state); end
    checks++; if (loader_reset !== 1'b0) begin errors++; $display("FAIL cyc1_loader_reset got %b exp 0", loader_reset); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL cyc1_core_reset got %b exp 1", core_reset); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL cyc1_rx_ready_hi got %b exp 1", bus.rx_ready); end
    bus.loader_ready = 1'b0;
    #1;
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL cyc1_rx_ready_lo got %b exp 0", bus.rx_ready); end
    idle_inputs();
  endtask

  task automatic test_load_run();
    go_load();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    @(negedge clk);
    checks++; if (bus.loader_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", bus.loader_valid); end
    checks++; if (bus.loader_data !== 8'hA5) begin errors++; $display("FAIL load_data got %0h exp a5", bus.loader_data); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL load_rx_ready got %b exp 1", bus.rx_ready); end
    checks++; if (bus.core_rx_valid !== 1'b0) begin errors++; $display("FAIL load_core_valid got %b exp 0", bus.core_rx_valid); end
    step();
    send_bytes(7, 8'h10);
    complete();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL settle_state[%0d] got %0d exp 2", i, state); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL settle_rx_ready[%0d] got %b exp 0", i, bus.rx_ready); end
      checks++; if (bus.loader_valid !== 1'b0) begin errors++; $display("FAIL settle_loader_valid[%0d] got %b exp 0", i, bus.loader_valid); end
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL settle_core_reset[%0d] got %b exp 1", i, core_reset); end
      step();
    end
    bus.core_rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL run_state got %0d exp 3", state); end
    checks++; if (booted !== 1'b1) begin errors++; $display("FAIL run_booted got %b exp 1", booted); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL run_core_reset got %b exp 0", core_reset); end
    checks++; if (bus.loader_valid !== 1'b0) begin errors++; $display("FAIL run_loader_valid got %b exp 0", bus.loader_valid); end
    checks++; if (bus.core_rx_valid !== 1'b1) begin errors++; $display("FAIL run_core_valid_hi got %b exp 1", bus.core_rx_valid); end
    checks++; if (bus.core_rx_data !== 8'h3C) begin errors++; $display("FAIL run_core_data got %0h exp 3c", bus.core_rx_data); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL run_rx_ready got %b exp 1", bus.rx_ready); end
    bus.rx_valid = 1'b0;
    #1;
    checks++; if (bus.core_rx_valid !== 1'b0) begin errors++; $display("FAIL run_core_valid_lo got %b exp 0", bus.core_rx_valid); end
    complete();
    @(negedge clk);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL run_ignores_completed got %0d exp 3", state); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    go_load();
    send_bytes(1, 8'h55);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_wait_state[%0d] got %0d exp 1", i, state); end
      step();
    end
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL to_state got %0d exp 0", state); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL to_load_error got %b exp 1", load_error); end
    checks++; if (loader_reset !== 1'b1) begin errors++; $display("FAIL to_loader_reset got %b exp 1", loader_reset); end
    step();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_reload_state got %0d exp 1", state); end
    repeat (12) step();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL unarmed_state got %0d exp 1", state); end
    reload_request = 1'b1;
    step();
    reload_request = 1'b0;
    @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL err_after_reload got %b exp 1", load_error); end
    step();
    send_bytes(1, 8'h66);
    @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL err_before_settle got %b exp 1", load_error); end
    complete();
    @(negedge clk);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL err_clear_state got %0d exp 2", state); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", load_error); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    go_load();
    send_bytes(1, 8'h77);
    bus.rx_valid     = 1'b1;
    bus.loader_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL bp_state[%0d] got %0d exp 1", i, state); end
      step();
    end
    @(negedge clk);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL bp_load_error got %b exp 0", load_error); end
    idle_inputs();
  endtask

  task automatic test_reload_run();
    boot_to_run();
    @(negedge clk);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL rl_pre_state got %0d exp 3", state); end
    reload_request = 1'b1;
    step();
    reload_request = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rl_state0 got %0d exp 0", state); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rl_core_reset got %b exp 1", core_reset); end
    checks++; if (booted !== 1'b0) begin errors++; $display("FAIL rl_booted got %b exp 0", booted); end
    step();
    bus.rx_valid      = 1'b1;
    bus.rx_data       = 8'h9A;
    bus.loader_ready  = 1'b1;
    bus.core_rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rl_state1 got %0d exp 1", state); end
    checks++; if (bus.loader_valid !== 1'b1) begin errors++; $display("FAIL rl_loader_valid got %b exp 1", bus.loader_valid); end
    checks++; if (bus.loader_data !== 8'h9A) begin errors++; $display("FAIL rl_loader_data got %0h exp 9a", bus.loader_data); end
    checks++; if (bus.core_rx_valid !== 1'b0) begin errors++; $display("FAIL rl_core_valid got %b exp 0", bus.core_rx_valid); end
    bus.rx_valid   = 1'b0;
    reload_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL hold_state[%0d] got %0d exp 0", i, state); end
      checks++; if (loader_reset !== 1'b1) begin errors++; $display("FAIL hold_loader_reset[%0d] got %b exp 1", i, loader_reset); end
    end
    reload_request = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL hold_release got %0d exp 1", state); end
    idle_inputs();
  endtask

  task automatic test_priority();
    go_load();
    send_bytes(1, 8'h01);
    loader_completed = 1'b1;
    reload_request   = 1'b1;
    step();
    loader_completed = 1'b0;
    reload_request   = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL pri_reload_state got %0d exp 0", state); end
    step();
    send_bytes(1, 8'h02);
    repeat (7) step();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL pri_pre_to_state got %0d exp 1", state); end
    complete();
    @(negedge clk);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pri_cmp_state got %0d exp 2", state); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL pri_cmp_load_error got %b exp 0", load_error); end
    go_load();
    send_bytes(1, 8'h03);
    repeat (7) step();
    reload_request = 1'b1;
    step();
    reload_request = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL pri_rl_to_state got %0d exp 0", state); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL pri_rl_to_load_error got %b exp 0", load_error); end
    do_reset();
    loader_completed = 1'b1;
    step();
    loader_completed = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL init_ignores_completed got %0d exp 1", state); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_run();
    test_timeout();
    test_backpressure();
    test_reload_run();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
